// File: rtl/pit_pkg.sv
// Shared definitions for the PIT interrupt-pending controller: FSM encoding
// and parameter defaults.
package pit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GAP    = 2'd2
    } pit_state_e;

    localparam int PEND_W_DEF     = 4;
    localparam int DEB_CYCLES_DEF = 3;

endpackage

// File: rtl/pit_ack_sync.sv
// Pad conditioning: 2-flop synchronizer, saturating debounce counter and a
// single-cycle pulse per accepted high period of the pin.
module pit_ack_sync #(
    parameter int DEB_CYCLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic pulse_o
);

    localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES);
    localparam logic [3:0] DEB_PREV = 4'(DEB_CYCLES - 1);

    logic       sync1_q, sync2_q;
    logic [3:0] cnt_q, cnt_d;
    logic       pulse_q, pulse_d;

    // The counter saturates at DEB_CYCLES so a long press yields one pulse.
    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (!sync2_q) begin
            cnt_d = 4'd0;
        end else if (cnt_q != DEB_LAST) begin
            cnt_d   = cnt_q + 4'd1;
            pulse_d = (cnt_q == DEB_PREV);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= 4'd0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/pit_irq_ctrl.sv
// Counts timer ticks, presents a level interrupt with a one-cycle low gap
// between successive pending interrupts, and retires one per debounced ack.
module pit_irq_ctrl
    import pit_pkg::*;
#(
    parameter int PEND_W     = PEND_W_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              irq_in,
    input  logic              irq_en,
    input  logic              ack_pin,
    output logic              irq_out,
    output logic [PEND_W-1:0] pending,
    output logic              overflow,
    output logic [1:0]        dbg_state_o
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic              ack_pulse;
    logic              inc, dec;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              overflow_q, overflow_d;
    logic              irq_out_q;
    pit_state_e        state_q, state_d;

    pit_ack_sync #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_ack_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_i  (ack_pin),
        .pulse_o(ack_pulse)
    );

    assign inc = irq_in & irq_en;
    assign dec = ack_pulse & (pending_q != '0);

    // Simultaneous inc and dec cancel out and leave overflow untouched.
    always_comb begin
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (inc && !dec) begin
            if (pending_q == PEND_MAX) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + PEND_ONE;
            end
        end else if (dec && !inc) begin
            pending_d = pending_q - PEND_ONE;
            if (pending_q == PEND_ONE) begin
                overflow_d = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (pending_d != '0) state_d = ST_ASSERT;
            ST_ASSERT: if (dec) state_d = ST_GAP;
            ST_GAP:    state_d = (pending_d != '0) ? ST_ASSERT : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // irq_out gets its own flop so the pad sees a glitch-free level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            irq_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            irq_out_q  <= (state_d == ST_ASSERT);
        end
    end

    assign irq_out     = irq_out_q;
    assign pending     = pending_q;
    assign overflow    = overflow_q;
    assign dbg_state_o = state_q;

endmodule
